// File: rtl/hazard_forward_ctrl_if.sv
// rtl/hazard_forward_ctrl_if.sv - ID-stage tags in, operand-forwarding selects and stall/freeze controls out
`ifndef LEN_FORW_SEL
`define LEN_FORW_SEL 2
`define FORW_SEL_FROM_ID  2'd0
`define FORW_SEL_FROM_MEM 2'd1
`define FORW_SEL_FROM_WB  2'd2
`endif

interface hazard_forward_ctrl_if #(parameter int REG_ADDR_W = 4);
    localparam int SLOT_W = REG_ADDR_W + 3;

    logic                     id_valid;
    logic [REG_ADDR_W-1:0]    id_src1;
    logic [REG_ADDR_W-1:0]    id_src2;
    logic                     id_two_src;
    logic [REG_ADDR_W-1:0]    id_dest;
    logic                     id_wb_en;
    logic                     id_mem_read;
    logic                     branch_taken;
    logic                     mem_ready;
    logic [`LEN_FORW_SEL-1:0] forw_sel_op1;
    logic [`LEN_FORW_SEL-1:0] forw_sel_op2;
    logic                     hazard_stall;
    logic                     pipe_freeze;
    // {wb, mem, ex}, each {valid, dest, wb_en, mem_read}
    logic [3*SLOT_W-1:0]      slot_dbg;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_read,
               branch_taken, mem_ready,
        input  forw_sel_op1, forw_sel_op2, hazard_stall, pipe_freeze, slot_dbg
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_read,
               branch_taken, mem_ready,
        output forw_sel_op1, forw_sel_op2, hazard_stall, pipe_freeze, slot_dbg
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX hazard scheduler: shadow EX/MEM/WB tags, RAW stall, forwarding selects (FORWARDING_EN)
`ifndef LEN_FORW_SEL
`define LEN_FORW_SEL 2
`define FORW_SEL_FROM_ID  2'd0
`define FORW_SEL_FROM_MEM 2'd1
`define FORW_SEL_FROM_WB  2'd2
`endif

module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    hazard_forward_ctrl_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } slot_t;

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    slot_t id_slot;

    function automatic logic hit(input slot_t s, input logic [REG_ADDR_W-1:0] src);
        return s.valid && s.wb_en && (s.dest == src);
    endfunction

    assign id_slot = '{valid: 1'b1, dest: bus.id_dest, wb_en: bus.id_wb_en, mem_read: bus.id_mem_read};

    logic src1_ex, src2_ex, src1_mem, src2_mem;
    assign src1_ex  = bus.id_valid & hit(ex_q, bus.id_src1);
    assign src2_ex  = bus.id_valid & bus.id_two_src & hit(ex_q, bus.id_src2);
    assign src1_mem = bus.id_valid & hit(mem_q, bus.id_src1);
    assign src2_mem = bus.id_valid & bus.id_two_src & hit(mem_q, bus.id_src2);

    logic stall;
`ifdef FORWARDING_EN
    // Only a load still in EX cannot be bypassed; everything else forwards.
    assign stall = (src1_ex | src2_ex) & ex_q.mem_read;
`else
    assign stall = src1_ex | src2_ex | src1_mem | src2_mem;
`endif

    logic bubble;
    assign bubble = stall | bus.branch_taken | ~bus.id_valid;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (bus.mem_ready) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = bubble ? '0 : id_slot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef FORWARDING_EN
    logic [`LEN_FORW_SEL-1:0] sel1_q, sel1_d, sel2_q, sel2_d;

    // The producer now in EX will sit in MEM when the consumer reaches EX; it is the youngest.
    function automatic logic [`LEN_FORW_SEL-1:0] pick(input logic in_ex, input logic in_mem);
        if (in_ex)  return `FORW_SEL_FROM_MEM;
        if (in_mem) return `FORW_SEL_FROM_WB;
        return `FORW_SEL_FROM_ID;
    endfunction

    always_comb begin
        sel1_d = sel1_q;
        sel2_d = sel2_q;
        if (bus.mem_ready) begin
            sel1_d = bubble ? `FORW_SEL_FROM_ID : pick(src1_ex, src1_mem);
            sel2_d = bubble ? `FORW_SEL_FROM_ID : pick(src2_ex, src2_mem);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel1_q <= `FORW_SEL_FROM_ID;
            sel2_q <= `FORW_SEL_FROM_ID;
        end else begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
        end
    end

    assign bus.forw_sel_op1 = sel1_q;
    assign bus.forw_sel_op2 = sel2_q;
`else
    assign bus.forw_sel_op1 = `FORW_SEL_FROM_ID;
    assign bus.forw_sel_op2 = `FORW_SEL_FROM_ID;
`endif

    assign bus.hazard_stall = stall;
    assign bus.pipe_freeze  = ~bus.mem_ready;
    assign bus.slot_dbg     = {wb_q, mem_q, ex_q};

endmodule
